// File: rtl/matrix_ops_pkg.sv
// Shared types and default sizing for the matrix-vector multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matrix_ops_pkg;

    localparam int DEF_MATRIX_WIDTH  = 2;
    localparam int DEF_MATRIX_HEIGHT = 2;
    localparam int DEF_DATA_WIDTH    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mvm_state_t;

endpackage

// File: rtl/mvm_mac.sv
// Single multiply-accumulate step; wraps modulo 2^DATA_WIDTH, or saturates when MATRIX_MULT_VECTOR_SAT_EN is defined.
// Latency: combinational.
// Backpressure: none; caller registers the result.
module mvm_mac
    import matrix_ops_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] acc_in,
    input  logic [DATA_WIDTH-1:0] mat_elem,
    input  logic [DATA_WIDTH-1:0] vec_elem,
    output logic [DATA_WIDTH-1:0] acc_out
);

`ifdef MATRIX_MULT_VECTOR_SAT_EN
    logic [2*DATA_WIDTH-1:0] prod_full;
    logic [DATA_WIDTH-1:0]   prod;
    logic [DATA_WIDTH:0]     sum_full;

    always_comb begin
        prod_full = mat_elem * vec_elem;
        // Clamp the product first so the adder only ever sees in-range operands.
        prod      = (|prod_full[2*DATA_WIDTH-1:DATA_WIDTH]) ? '1 : prod_full[DATA_WIDTH-1:0];
        sum_full  = {1'b0, acc_in} + {1'b0, prod};
        acc_out   = sum_full[DATA_WIDTH] ? '1 : sum_full[DATA_WIDTH-1:0];
    end
`else
    logic [DATA_WIDTH-1:0] prod;

    always_comb begin
        prod    = mat_elem * vec_elem;
        acc_out = acc_in + prod;
    end
`endif

endmodule

// File: rtl/matrix_mult_vector.sv
// Matrix-vector multiply y = M*v, one MAC per cycle in row-major order; MATRIX_MULT_VECTOR_SAT_EN selects saturating arithmetic.
// Latency: MATRIX_WEIGHT edges after the start edge until o_ready.
// Backpressure: none; i_calc is ignored while busy, result held until next start or reset.
module matrix_mult_vector
    import matrix_ops_pkg::*;
#(
    parameter int MATRIX_WIDTH  = DEF_MATRIX_WIDTH,
    parameter int MATRIX_HEIGHT = DEF_MATRIX_HEIGHT,
    parameter int MATRIX_WEIGHT = MATRIX_WIDTH * MATRIX_HEIGHT,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
    input  logic                                clk,
    input  logic                                i_rst,
    input  logic                                i_calc,
    input  logic [MATRIX_WEIGHT*DATA_WIDTH-1:0] i_matrix,
    input  logic [MATRIX_WIDTH*DATA_WIDTH-1:0]  i_vector,
    output logic [MATRIX_WEIGHT*DATA_WIDTH-1:0] o_result,
    output logic                                o_ready
);

    localparam int CW = (MATRIX_WIDTH  > 1) ? $clog2(MATRIX_WIDTH)  : 1;
    localparam int RW = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;

    mvm_state_t state_q, state_d;
    logic       start;
    logic       row_end;
    logic       last_mac;

    logic [DATA_WIDTH-1:0] mat_q [MATRIX_HEIGHT][MATRIX_WIDTH];
    logic [DATA_WIDTH-1:0] vec_q [MATRIX_WIDTH];

    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] mac_out;
    logic [CW-1:0]         col_q;
    logic [RW-1:0]         row_q;
    logic [MATRIX_HEIGHT-1:0][DATA_WIDTH-1:0] res_q;
    logic                  ready_q;

    assign row_end  = (col_q == CW'(MATRIX_WIDTH - 1));
    assign last_mac = row_end && (row_q == RW'(MATRIX_HEIGHT - 1));

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (i_calc) begin
                    state_d = CALC;
                    start   = 1'b1;
                end
            end
            CALC: begin
                if (last_mac) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand snapshot: inputs may change freely once the operation is running.
    always_ff @(posedge clk) begin
        if (start) begin
            for (int r = 0; r < MATRIX_HEIGHT; r++) begin
                for (int c = 0; c < MATRIX_WIDTH; c++) begin
                    mat_q[r][c] <= i_matrix[(r*MATRIX_WIDTH + c)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            for (int c = 0; c < MATRIX_WIDTH; c++) begin
                vec_q[c] <= i_vector[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    mvm_mac #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mac (
        .acc_in   (acc_q),
        .mat_elem (mat_q[row_q][col_q]),
        .vec_elem (vec_q[col_q]),
        .acc_out  (mac_out)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            res_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                acc_q   <= '0;
                col_q   <= '0;
                row_q   <= '0;
                ready_q <= 1'b0;
            end else if (state_q == CALC) begin
                if (row_end) begin
                    // Row finished: publish it and start the next row from a clean accumulator.
                    res_q[row_q] <= mac_out;
                    acc_q        <= '0;
                    col_q        <= '0;
                    row_q        <= last_mac ? '0 : row_q + 1'b1;
                    if (last_mac) begin
                        ready_q <= 1'b1;
                    end
                end else begin
                    acc_q <= mac_out;
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_result = '0;
        o_result[MATRIX_HEIGHT*DATA_WIDTH-1:0] = res_q;
    end

    assign o_ready = ready_q;

endmodule

// File: tb/tb_matrix_mult_vector.sv
// Directed self-checking bench for matrix_mult_vector: default 2x2 instance and a 3x1 instance.
module tb_matrix_mult_vector;

    logic        clk;
    logic        rst;
    logic        calc_a;
    logic [31:0] matrix_a;
    logic [15:0] vector_a;
    logic [31:0] result_a;
    logic        ready_a;

    logic        calc_b;
    logic [23:0] matrix_b;
    logic [23:0] vector_b;
    logic [23:0] result_b;
    logic        ready_b;

    int checks   = 0;
    int failures = 0;

`ifdef MATRIX_MULT_VECTOR_SAT_EN
    localparam logic [31:0] EXP_A = 32'h0000_3EFF;
`else
    localparam logic [31:0] EXP_A = 32'h0000_3E00;
`endif
    localparam logic [31:0] MAT_A = {8'd2, 8'd3, 8'd6, 8'd14};
    localparam logic [15:0] VEC_A = {8'd10, 8'd14};

    matrix_mult_vector u_dut_a (
        .clk      (clk),
        .i_rst    (rst),
        .i_calc   (calc_a),
        .i_matrix (matrix_a),
        .i_vector (vector_a),
        .o_result (result_a),
        .o_ready  (ready_a)
    );

    matrix_mult_vector #(
        .MATRIX_WIDTH  (3),
        .MATRIX_HEIGHT (1),
        .MATRIX_WEIGHT (3),
        .DATA_WIDTH    (8)
    ) u_dut_b (
        .clk      (clk),
        .i_rst    (rst),
        .i_calc   (calc_b),
        .i_matrix (matrix_b),
        .i_vector (vector_b),
        .o_result (result_b),
        .o_ready  (ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        calc_a   = 1'b0;
        calc_b   = 1'b0;
        matrix_a = MAT_A;
        vector_a = VEC_A;
        matrix_b = {8'd3, 8'd2, 8'd1};
        vector_b = {8'd6, 8'd5, 8'd4};
        tick();
        tick();
        chk("rst_ready_a",  {31'd0, ready_a}, 32'd0);
        chk("rst_result_a", result_a, 32'd0);
        chk("rst_ready_b",  {31'd0, ready_b}, 32'd0);
        chk("rst_result_b", {8'd0, result_b}, 32'd0);
        rst = 1'b0;
        tick();

        // Single pulse, 4-edge latency.
        calc_a = 1'b1;
        tick();
        calc_a = 1'b0;
        chk("start_ready_low", {31'd0, ready_a}, 32'd0);
        tick(); tick(); tick();
        chk("edge3_not_ready", {31'd0, ready_a}, 32'd0);
        tick();
        chk("edge4_ready", {31'd0, ready_a}, 32'd1);
        chk("edge4_result", result_a, EXP_A);
        tick(); tick();
        chk("done_hold_ready", {31'd0, ready_a}, 32'd1);
        chk("done_hold_result", result_a, EXP_A);

        // Reset in the second CALC cycle aborts, then a restart completes.
        calc_a = 1'b1;
        tick();
        calc_a = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready", {31'd0, ready_a}, 32'd0);
        chk("abort_result", result_a, 32'd0);
        tick(); tick();
        chk("idle_after_abort", {31'd0, ready_a}, 32'd0);
        calc_a = 1'b1;
        tick();
        calc_a = 1'b0;
        tick(); tick(); tick(); tick();
        chk("restart_ready", {31'd0, ready_a}, 32'd1);
        chk("restart_result", result_a, EXP_A);

        // Inputs and i_calc disturbed mid-operation.
        calc_a = 1'b1;
        tick();
        calc_a   = 1'b0;
        matrix_a = 32'd0;
        vector_a = 16'hFFFF;
        tick();
        calc_a = 1'b1;
        tick();
        calc_a = 1'b0;
        tick();
        chk("stable_not_ready", {31'd0, ready_a}, 32'd0);
        tick();
        chk("stable_ready", {31'd0, ready_a}, 32'd1);
        chk("stable_result", result_a, EXP_A);
        matrix_a = MAT_A;
        vector_a = VEC_A;

        // Continuous i_calc: one-cycle ready pulse every 5 cycles.
        calc_a = 1'b1;
        tick();
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk($sformatf("b2b_ready_k%0d", k), {31'd0, ready_a}, {31'd0, (k % 5) == 4});
            if ((k % 5) == 4) begin
                chk($sformatf("b2b_result_k%0d", k), result_a, EXP_A);
            end
        end
        calc_a = 1'b0;
        tick(); tick(); tick(); tick();
        chk("b2b_final_ready", {31'd0, ready_a}, 32'd1);

        // 3x1 instance: y0 = 1*4 + 2*5 + 3*6 = 32.
        calc_b = 1'b1;
        tick();
        calc_b = 1'b0;
        tick(); tick();
        chk("b_edge2_not_ready", {31'd0, ready_b}, 32'd0);
        tick();
        chk("b_edge3_ready", {31'd0, ready_b}, 32'd1);
        chk("b_result", {8'd0, result_b}, 32'd32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_mult_vector.md
MATRIX_MULT_VECTOR -- requirements
Module: matrix_mult_vector

Interface
REQ-001 SHALL have parameter MATRIX_WIDTH, default 2, meaning the number of matrix columns, which equals the vector length.
REQ-002 SHALL have parameter MATRIX_HEIGHT, default 2, meaning the number of matrix rows.
REQ-003 SHALL have parameter MATRIX_WEIGHT, default MATRIX_WIDTH*MATRIX_HEIGHT, meaning the element count; it is always overridden consistently.
REQ-004 SHALL have parameter DATA_WIDTH, default 8, meaning the bits per element, unsigned.
REQ-005 SHALL have port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port i_rst, input, width 1: reset, synchronous and active-high.
REQ-007 SHALL have port i_calc, input, width 1: start request, level-sampled.
REQ-008 SHALL have port i_matrix, input, MATRIX_WEIGHT*DATA_WIDTH bits: M[r][c] sits at bits [(r*MATRIX_WIDTH+c)*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port i_vector, input, MATRIX_WIDTH*DATA_WIDTH bits: v[c] sits at bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port o_result, output, MATRIX_WEIGHT*DATA_WIDTH bits: y[r] sits at bits [r*DATA_WIDTH +: DATA_WIDTH] for r<MATRIX_HEIGHT; all higher bits are 0.
REQ-011 SHALL have port o_ready, output, width 1: result valid.

Function
REQ-012 SHALL compute y[r] = sum over c of M[r][c]*v[c], unsigned, with each product and the accumulator truncated modulo 2^DATA_WIDTH.
REQ-013 SHALL use an FSM with states IDLE, CALC and DONE.
- IDLE -> CALC on an edge with i_calc=1.
- CALC -> DONE after the last MAC.
- DONE -> CALC on an edge with i_calc=1.
REQ-014 SHALL, on the start edge, latch i_matrix and i_vector internally, clear the accumulator, set the row and column indices to 0, and drive o_ready to 0.
REQ-015 SHALL perform exactly one MAC per CALC cycle in row-major order: c is the inner index and r the outer.
REQ-016 SHALL, at the end of each row, write that row's y[r] into o_result.
REQ-017 SHALL have a latency of N=MATRIX_WEIGHT edges after the start edge: o_ready=1 and o_result complete immediately after edge N.
REQ-018 SHALL hold o_ready=1 and o_result stable in DONE until the next start or reset.
REQ-019 SHALL ignore i_calc while in CALC; changes to the inputs during CALC do not affect the result.
REQ-020 SHALL, when i_calc is held high continuously, restart on the first DONE cycle, so o_ready pulses for one cycle.

Reset
REQ-021 SHALL, on an edge with i_rst=1, go to IDLE and drive o_result=0 and o_ready=0, clearing the accumulator and indices.
REQ-022 SHALL give i_rst priority over i_calc; a reset during CALC aborts the operation with no partial result visible.

Configuration
REQ-023 SHALL, when macro MATRIX_MULT_VECTOR_SAT_EN is defined, saturate each product and accumulation at 2^DATA_WIDTH-1 instead of wrapping.
REQ-024 SHALL, when the macro is undefined, use modulo arithmetic per REQ-012.

Structure
REQ-025 SHALL take the FSM state enum and the default parameter constants from the shared package matrix_ops_pkg.
REQ-026 SHALL implement the multiply-accumulate, including the saturate option, in one sub-module named mvm_mac.

Verification
REQ-027 SHALL cover the default 2x2 case: i_matrix={8'd2,8'd3,8'd6,8'd14} (MSB first) and i_vector={8'd10,8'd14}, with i_calc pulsed once.
- Required response: o_ready=1 after 4 edges, o_result[7:0]=0 (256 wrapped), o_result[15:8]=62, o_result[31:16]=0.
REQ-028 SHALL cover the same stimulus with MATRIX_MULT_VECTOR_SAT_EN defined -> o_result[7:0]=255, o_result[15:8]=62.
REQ-029 SHALL cover reset: assert i_rst during the second CALC cycle -> o_ready=0 and o_result=0 on the next edge; a restart then yields the REQ-027 values.
REQ-030 SHALL cover input stability: change i_matrix to all-zero during CALC -> the result still matches the REQ-027 values.
REQ-031 SHALL cover back-to-back use: hold i_calc=1 -> o_ready is high for 1 cycle every 5 cycles, with the result stable in each ready cycle.
REQ-032 SHALL cover a non-default case: MATRIX_WIDTH=3, MATRIX_HEIGHT=1, M={1,2,3}, v={4,5,6}, stored with element index 0 at the LSBs.
- Required response: o_ready=1 after 3 edges, y[0]=32, and o_result upper bits=0.
